// File: rtl/clkdiv_pkg.sv
// Shared constants and per-channel configuration type for the clock divider bank.
package clkdiv_pkg;

    localparam int unsigned N_DEF       = 4;
    localparam int unsigned CW_DEF      = 8;
    localparam int unsigned NSTABLE_DEF = 8;
    localparam int unsigned CW_MAX      = 16;
    localparam int unsigned SW          = 8;

    // Edge counts are held at the widest legal width; narrower banks zero-extend.
    typedef struct packed {
        logic [CW_MAX-1:0] rise;
        logic [CW_MAX-1:0] fall;
        logic              half;
    } chan_cfg_t;

endpackage

// File: rtl/clkdiv_chan.sv
// One divided-clock channel: edge compare, output register and optional half-cycle delay.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk,
    input  logic          nreset,
    input  logic [CW-1:0] cnt,
    input  logic          div_nz,
    input  chan_cfg_t     cfg,
    input  logic          chen,
    output logic          clkrise,
    output logic          clkfall,
    output logic          clkout
);

    logic out_q, out_d;
    logic neg_q, neg_d;

    assign clkrise = chen & div_nz & (CW_MAX'(cnt) == cfg.rise);
    assign clkfall = chen & div_nz & (CW_MAX'(cnt) == cfg.fall);

    // Rise has priority over fall; disabling the channel clears the output.
    always_comb begin
        out_d = out_q;
        neg_d = out_q;
        if (!chen) begin
            out_d = 1'b0;
        end else if (clkrise) begin
            out_d = 1'b1;
        end else if (clkfall) begin
            out_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) out_q <= 1'b0;
        else         out_q <= out_d;
    end

    // Half-cycle stage delays the output by half a clk period.
    always_ff @(negedge clk or negedge nreset) begin
        if (!nreset) neg_q <= 1'b0;
        else         neg_q <= neg_d;
    end

    assign clkout = cfg.half ? neg_q : out_q;

endmodule

// File: rtl/clkdiv_bank.sv
// Bank of N phase-programmable clock dividers sharing one period counter,
// with a valid/ready configuration port applied only on period boundaries.
module clkdiv_bank
    import clkdiv_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned CW      = CW_DEF,
    parameter int unsigned NSTABLE = NSTABLE_DEF
) (
    input  logic            clk,
    input  logic            nreset,
    input  logic            clken,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [CW-1:0]   cfg_div,
    input  logic [N*CW-1:0] cfg_rise,
    input  logic [N*CW-1:0] cfg_fall,
    input  logic [N-1:0]    cfg_half,
    input  logic [N-1:0]    chen,
    output logic [N-1:0]    clkout,
    output logic [N-1:0]    clkrise,
    output logic [N-1:0]    clkfall,
    output logic            period_tick,
    output logic            clkstable
);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        div_q, div_d;
    logic [CW-1:0]        div_sh_q, div_sh_d;
    chan_cfg_t [N-1:0]    act_q, act_d;
    chan_cfg_t [N-1:0]    sh_q, sh_d;
    logic                 pend_q, pend_d;
    logic                 rdy_q, rdy_d;
    logic [SW-1:0]        stab_q, stab_d;
    logic                 div_nz_c, xfer_c, apply_c;

    assign div_nz_c    = (div_q != '0);
    assign period_tick = clken & div_nz_c & (cnt_q == div_q);
    assign xfer_c      = cfg_valid & rdy_q;
    assign apply_c     = pend_q & (period_tick | ~div_nz_c);
    assign cfg_ready   = rdy_q;
    assign clkstable   = (stab_q == SW'(NSTABLE)) & div_nz_c;

    always_comb begin
        cnt_d    = cnt_q;
        div_d    = div_q;
        div_sh_d = div_sh_q;
        act_d    = act_q;
        sh_d     = sh_q;
        pend_d   = pend_q;
        stab_d   = stab_q;
        // Apply swaps in the whole shadow at once so no period mixes old and new settings.
        if (apply_c) begin
            div_d  = div_sh_q;
            act_d  = sh_q;
            cnt_d  = '0;
            stab_d = '0;
            pend_d = 1'b0;
        end else begin
            if (!div_nz_c) begin
                cnt_d = '0;
            end else if (clken) begin
                cnt_d = (cnt_q == div_q) ? '0 : cnt_q + CW'(1);
            end
            if (period_tick && (stab_q != SW'(NSTABLE))) begin
                stab_d = stab_q + SW'(1);
            end
        end
        if (xfer_c) begin
            div_sh_d = cfg_div;
            pend_d   = 1'b1;
            for (int unsigned i = 0; i < N; i++) begin
                sh_d[i].rise = CW_MAX'(cfg_rise[i*CW +: CW]);
                sh_d[i].fall = CW_MAX'(cfg_fall[i*CW +: CW]);
                sh_d[i].half = cfg_half[i];
            end
        end
        rdy_d = ~pend_d;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt_q    <= '0;
            div_q    <= '0;
            div_sh_q <= '0;
            act_q    <= '0;
            sh_q     <= '0;
            pend_q   <= 1'b0;
            rdy_q    <= 1'b1;
            stab_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            div_sh_q <= div_sh_d;
            act_q    <= act_d;
            sh_q     <= sh_d;
            pend_q   <= pend_d;
            rdy_q    <= rdy_d;
            stab_q   <= stab_d;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_chan
        clkdiv_chan #(.CW(CW)) u_chan (
            .clk     (clk),
            .nreset  (nreset),
            .cnt     (cnt_q),
            .div_nz  (div_nz_c),
            .cfg     (act_q[g]),
            .chen    (chen[g]),
            .clkrise (clkrise[g]),
            .clkfall (clkfall[g]),
            .clkout  (clkout[g])
        );
    end

endmodule

// File: tb/tb_clkdiv_bank.sv
// Scoreboarded bench for clkdiv_bank: directed scenarios followed by random traffic.
module tb_clkdiv_bank;

    localparam int N   = 4;
    localparam int CW  = 8;
    localparam int NST = 8;

    logic            clk = 1'b0;
    logic            nreset, clken, cfg_valid, cfg_ready;
    logic [CW-1:0]   cfg_div;
    logic [N*CW-1:0] cfg_rise, cfg_fall;
    logic [N-1:0]    cfg_half, chen, clkout, clkrise, clkfall;
    logic            period_tick, clkstable;

    clkdiv_bank #(.N(N), .CW(CW), .NSTABLE(NST)) dut (
        .clk(clk), .nreset(nreset), .clken(clken), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .cfg_div(cfg_div), .cfg_rise(cfg_rise),
        .cfg_fall(cfg_fall), .cfg_half(cfg_half), .chen(chen), .clkout(clkout),
        .clkrise(clkrise), .clkfall(clkfall), .period_tick(period_tick),
        .clkstable(clkstable)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] flags;
        logic [N-1:0] rise, fall, hi, lo;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural reference: position within the period plus the configured edge positions.
    int m_pos, m_per, m_stab, m_sper;
    int m_rise[N], m_fall[N], m_srise[N], m_sfall[N];
    bit m_half[N], m_shalf[N], m_out[N], m_neg[N];
    bit m_pend;

    // Staged stimulus for the next cycle.
    logic            s_nreset, s_clken, s_valid;
    logic [CW-1:0]   s_div;
    logic [N*CW-1:0] s_rise, s_fall;
    logic [N-1:0]    s_half, s_chen;

    task automatic model_reset();
        m_pos = 0; m_per = 0; m_stab = 0; m_sper = 0; m_pend = 0;
        for (int i = 0; i < N; i++) begin
            m_rise[i] = 0; m_fall[i] = 0; m_srise[i] = 0; m_sfall[i] = 0;
            m_half[i] = 0; m_shalf[i] = 0; m_out[i] = 0; m_neg[i] = 0;
        end
    endtask

    task automatic set_ch(input int ch, input int r, input int f, input bit h);
        s_rise[ch*CW +: CW] = CW'(r);
        s_fall[ch*CW +: CW] = CW'(f);
        s_half[ch] = h;
    endtask

    task automatic cyc();
        exp_t e;
        bit   tick, r, f, xfer, apply;
        bit   nout[N];
        @(posedge clk);
        #1;
        nreset = s_nreset; clken = s_clken; cfg_valid = s_valid; cfg_div = s_div;
        cfg_rise = s_rise; cfg_fall = s_fall; cfg_half = s_half; chen = s_chen;
        if (!s_nreset) model_reset();
        tick = s_clken && (m_per != 0) && (m_pos == m_per);
        e.flags = '0;
        e.flags[0] = tick;
        e.flags[1] = (m_stab == NST) && (m_per != 0);
        e.flags[2] = !m_pend;
        for (int i = 0; i < N; i++) begin
            r = s_chen[i] && (m_per != 0) && (m_pos == m_rise[i]);
            f = s_chen[i] && (m_per != 0) && (m_pos == m_fall[i]);
            e.rise[i] = r;
            e.fall[i] = f;
            e.hi[i]   = m_half[i] ? m_neg[i] : m_out[i];
            m_neg[i]  = m_out[i];
            e.lo[i]   = m_half[i] ? m_neg[i] : m_out[i];
            nout[i]   = !s_chen[i] ? 1'b0 : r ? 1'b1 : f ? 1'b0 : m_out[i];
        end
        q.push_back(e);
        s_valid = 1'b0;
        if (s_nreset) begin
            for (int i = 0; i < N; i++) m_out[i] = nout[i];
            xfer  = cfg_valid && !m_pend;
            apply = m_pend && (tick || m_per == 0);
            if (apply) begin
                m_per = m_sper; m_pos = 0; m_stab = 0; m_pend = 0;
                for (int i = 0; i < N; i++) begin
                    m_rise[i] = m_srise[i]; m_fall[i] = m_sfall[i]; m_half[i] = m_shalf[i];
                end
            end else begin
                if (m_per == 0)   m_pos = 0;
                else if (s_clken) m_pos = (m_pos + 1) % (m_per + 1);
                if (tick && m_stab < NST) m_stab++;
            end
            if (xfer) begin
                m_pend = 1;
                m_sper = int'(cfg_div);
                for (int i = 0; i < N; i++) begin
                    m_srise[i] = int'(cfg_rise[i*CW +: CW]);
                    m_sfall[i] = int'(cfg_fall[i*CW +: CW]);
                    m_shalf[i] = cfg_half[i];
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b required %b", name, $time, act, exp);
        end
    endtask

    // Monitor: pops one expectation per cycle, samples with clk high and again with clk low.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("flags(stable,ready,tick)", N'({clkstable ? 1'b0 : 1'b0, cfg_ready, clkstable, period_tick}) , e.flags);
                chk("clkrise", clkrise, e.rise);
                chk("clkfall", clkfall, e.fall);
                chk("clkout_hi", clkout, e.hi);
                #5;
                chk("clkout_lo", clkout, e.lo);
            end
        end
    end

    initial begin
        int d;
        nreset = 1'b0; clken = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        cfg_rise = '0; cfg_fall = '0; cfg_half = '0; chen = '0;
        s_nreset = 1'b0; s_clken = 1'b0; s_valid = 1'b0; s_div = '0;
        s_rise = '0; s_fall = '0; s_half = '0; s_chen = '1;
        model_reset();
        run(3);

        // Basic divide by 4 with a 2-cycle high phase.
        s_nreset = 1'b1; s_clken = 1'b1; s_div = 8'd3;
        set_ch(0, 0, 2, 0); set_ch(1, 1, 3, 0); set_ch(2, 0, 1, 0); set_ch(3, 2, 3, 0);
        s_valid = 1'b1;
        run(50);
        // Divide by 3 with half-cycle delayed channel 1.
        s_div = 8'd2; set_ch(1, 0, 1, 1); s_valid = 1'b1;
        run(30);
        // Reconfigure to divide by 8 mid-period.
        s_div = 8'd7; s_valid = 1'b1;
        run(100);
        // Coincident edges and an unreachable fall count.
        s_div = 8'd3; set_ch(2, 1, 1, 0); set_ch(3, 0, 5, 0); s_valid = 1'b1;
        run(30);
        // Drop and restore a channel enable.
        set_ch(2, 0, 2, 0); s_valid = 1'b1;
        run(21);
        s_chen[2] = 1'b0; run(1);
        s_chen[2] = 1'b1; run(12);
        // Reset while a configuration is pending.
        s_div = 8'd5; s_valid = 1'b1;
        run(2);
        s_nreset = 1'b0; run(2);
        s_nreset = 1'b1; run(10);

        for (int k = 0; k < 3000; k++) begin
            s_nreset = ($urandom_range(0, 299) != 0);
            s_clken  = ($urandom_range(0, 7) != 0);
            s_valid  = ($urandom_range(0, 5) == 0);
            d = $urandom_range(0, 19);
            s_div = (d == 0) ? 8'd0 : (d == 1) ? 8'd255 : CW'($urandom_range(1, 9));
            for (int i = 0; i < N; i++) begin
                set_ch(i, $urandom_range(0, (int'(s_div) + 2 > 255) ? 255 : int'(s_div) + 2),
                          $urandom_range(0, (int'(s_div) + 2 > 255) ? 255 : int'(s_div) + 2),
                          1'($urandom_range(0, 1)));
                if ($urandom_range(0, 19) == 0) s_chen[i] = ~s_chen[i];
            end
            cyc();
        end

        repeat (3) @(posedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d left required 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
